// File: rtl/gon_mc_ctrl_buffered.sv
// gon_mc_ctrl_buffered
//   Multicast tap controller for the PE-array global-on-network. It holds a
//   scan-loaded ID and don't-care mask, matches each upstream packet tag
//   against them, and buffers matching payloads in a small FIFO. The FIFO
//   decouples the upstream enable/ready handshake from the downstream one.
//
// Optional feature macro: GON_MC_BCAST_EN
//   When defined, an all-ones tag matches every tap regardless of id/mask.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   set_id              load id_in/mask_in on this clock edge
//   id_in, mask_in      new ID / mask from the scan chain (mask bit 1 = don't care)
//   id, mask            current ID / mask, forwarded along the scan chain
//   tag                 destination tag of the current upstream packet
//   enable_in/ready_out upstream valid/ready
//   value_in            upstream payload
//   enable_out/ready_in downstream valid/ready
//   value_out           downstream payload (0 while the FIFO is empty)
//   count               FIFO occupancy
module gon_mc_ctrl_buffered #(
    parameter int ID_LEN    = 4,
    parameter int VALUE_LEN = 32,
    parameter int DEPTH     = 2,
    localparam int CNT_LEN  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_id,
    input  logic [ID_LEN-1:0]    id_in,
    input  logic [ID_LEN-1:0]    mask_in,
    output logic [ID_LEN-1:0]    id,
    output logic [ID_LEN-1:0]    mask,
    input  logic [ID_LEN-1:0]    tag,
    input  logic                 enable_in,
    output logic                 ready_out,
    input  logic [VALUE_LEN-1:0] value_in,
    output logic                 enable_out,
    input  logic                 ready_in,
    output logic [VALUE_LEN-1:0] value_out,
    output logic [CNT_LEN-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_LEN-1:0]    id_q, mask_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_LEN-1:0]   count_q, count_d;
    logic [VALUE_LEN-1:0] mem [DEPTH];

    logic match_rule, match, full, empty, push, pop;

    // ID/mask register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q   <= '0;
            mask_q <= '0;
        end else if (set_id) begin
            id_q   <= id_in;
            mask_q <= mask_in;
        end
    end

    assign id   = id_q;
    assign mask = mask_q;

    assign match_rule = (((tag ^ id_q) & ~mask_q) == '0);

`ifdef GON_MC_BCAST_EN
    assign match = match_rule | (&tag);
`else
    assign match = match_rule;
`endif

    assign full  = (count_q == CNT_LEN'(DEPTH));
    assign empty = (count_q == '0);

    // Ready ignores ready_in when full, so a pop never frees a slot for the same cycle.
    assign ready_out  = match & ~full;
    assign enable_out = ~empty;
    assign push       = enable_in & ready_out;
    assign pop        = enable_out & ready_in;

    assign value_out = enable_out ? mem[rd_ptr_q] : '0;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_LEN'(1);
            2'b01:   count_d = count_q - CNT_LEN'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; enable_out masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= value_in;
    end

endmodule

// File: tb/tb_gon_mc_ctrl_buffered.sv
module tb_gon_mc_ctrl_buffered;

    localparam int ID_LEN    = 4;
    localparam int VALUE_LEN = 32;
    localparam int DEPTH     = 2;
    localparam int CNT_LEN   = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 set_id;
    logic [ID_LEN-1:0]    id_in, mask_in, id, mask, tag;
    logic                 enable_in, ready_out, enable_out, ready_in;
    logic [VALUE_LEN-1:0] value_in, value_out;
    logic [CNT_LEN-1:0]   count;

    gon_mc_ctrl_buffered #(
        .ID_LEN   (ID_LEN),
        .VALUE_LEN(VALUE_LEN),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_id    (set_id),
        .id_in     (id_in),
        .mask_in   (mask_in),
        .id        (id),
        .mask      (mask),
        .tag       (tag),
        .enable_in (enable_in),
        .ready_out (ready_out),
        .value_in  (value_in),
        .enable_out(enable_out),
        .ready_in  (ready_in),
        .value_out (value_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: registered id/mask and a queue of buffered payloads.
    logic [ID_LEN-1:0]    m_id, m_mask;
    logic [VALUE_LEN-1:0] m_q[$];
    logic [VALUE_LEN-1:0] obs_val;
    logic                 obs_rdy;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic model_match(input logic [ID_LEN-1:0] t);
        logic hit;
        hit = 1'b1;
        for (int b = 0; b < ID_LEN; b++)
            if (!m_mask[b] && (t[b] != m_id[b])) hit = 1'b0;
`ifdef GON_MC_BCAST_EN
        if (t == 4'hF) hit = 1'b1;
`endif
        return hit;
    endfunction

    // One clock cycle: drive at negedge, compare against the model, then
    // advance the model at the posedge.
    task automatic step(input logic sid, input logic [ID_LEN-1:0] idi, input logic [ID_LEN-1:0] mi,
                        input logic [ID_LEN-1:0] tg, input logic en,
                        input logic [VALUE_LEN-1:0] v, input logic rdy);
        logic exp_rdy, do_push, do_pop;
        @(negedge clk);
        set_id = sid; id_in = idi; mask_in = mi; tag = tg;
        enable_in = en; value_in = v; ready_in = rdy;
        #1;
        exp_rdy = model_match(tg) && (m_q.size() != DEPTH);
        check_eq("ready_out", 32'(ready_out), 32'(exp_rdy));
        check_eq("enable_out", 32'(enable_out), 32'(m_q.size() != 0));
        check_eq("value_out", value_out, (m_q.size() != 0) ? m_q[0] : 32'h0);
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("id", 32'(id), 32'(m_id));
        check_eq("mask", 32'(mask), 32'(m_mask));
        obs_val = value_out;
        obs_rdy = ready_out;
        do_push = en && exp_rdy;
        do_pop  = (m_q.size() != 0) && rdy;
        @(posedge clk);
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(v);
        if (sid) begin
            m_id   = idi;
            m_mask = mi;
        end
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic async_reset(input string name);
        @(negedge clk);
        enable_in = 1'b0; set_id = 1'b0; ready_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq({name, "_enable_out"}, 32'(enable_out), 32'h0);
        check_eq({name, "_count"}, 32'(count), 32'h0);
        check_eq({name, "_id"}, 32'(id), 32'h0);
        check_eq({name, "_value_out"}, value_out, 32'h0);
        m_q.delete();
        m_id = '0;
        m_mask = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set_id = 0; id_in = 0; mask_in = 0; tag = 0;
        enable_in = 0; value_in = 0; ready_in = 0;
        m_id = 0; m_mask = 0;
        #12;
        rst = 1'b0;

        // Basic accept and pass-through with one cycle latency
        step(1, 4'h3, 4'h0, 4'h0, 0, 0, 1);
        step(0, 0, 0, 4'h3, 1, 32'hA5A5_0001, 1);
        check_eq("tp1_ready", 32'(obs_rdy), 32'h1);
        step(0, 0, 0, 4'h3, 0, 0, 1);
        check_eq("tp1_value", obs_val, 32'hA5A5_0001);
        step(0, 0, 0, 4'h3, 0, 0, 1);

        // Masked match
        step(1, 4'h3, 4'h1, 4'h0, 0, 0, 1);
        step(0, 0, 0, 4'h2, 1, 32'h2, 1);
        check_eq("tp2_tag2", 32'(obs_rdy), 32'h1);
        step(0, 0, 0, 4'h3, 1, 32'h3, 1);
        check_eq("tp2_tag3", 32'(obs_rdy), 32'h1);
        step(0, 0, 0, 4'h1, 1, 32'h4, 1);
        check_eq("tp2_tag1", 32'(obs_rdy), 32'h0);
        step(0, 0, 0, 4'h1, 0, 0, 1);

        // Fill to full, then drain in order
        step(1, 4'h3, 4'h0, 4'h3, 0, 0, 1);
        step(0, 0, 0, 4'h3, 1, 32'h11, 0);
        step(0, 0, 0, 4'h3, 1, 32'h22, 0);
        step(0, 0, 0, 4'h3, 1, 32'h33, 0);
        check_eq("tp3_full_ready", 32'(obs_rdy), 32'h0);
        step(0, 0, 0, 4'h3, 1, 32'h33, 1);
        check_eq("tp3_full_pop_ready", 32'(obs_rdy), 32'h0);
        check_eq("tp3_first", obs_val, 32'h11);
        step(0, 0, 0, 4'h3, 0, 0, 1);
        check_eq("tp3_second", obs_val, 32'h22);
        step(0, 0, 0, 4'h3, 0, 0, 1);
        check_eq("tp3_refill_ready", 32'(obs_rdy), 32'h1);

        // Steady push+pop at count=1, wrapping pointers
        step(0, 0, 0, 4'h3, 1, 32'h0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 4'h3, 1, 32'(i), 1);
            check_eq("tp4_order", obs_val, 32'(i - 1));
        end

        // Stall keeps value_out stable
        step(0, 0, 0, 4'h3, 1, 32'hBEEF, 0);
        step(0, 0, 0, 4'h3, 0, 0, 0);
        step(0, 0, 0, 4'h3, 0, 0, 0);
        check_eq("stall_stable", obs_val, 32'h8);

        // Async reset with two entries buffered
        async_reset("tp5");

        // Broadcast tag
        step(1, 4'h5, 4'h0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 4'hF, 1, 32'hCAFE, 0);
`ifdef GON_MC_BCAST_EN
        check_eq("tp6_bcast", 32'(obs_rdy), 32'h1);
`else
        check_eq("tp6_bcast", 32'(obs_rdy), 32'h0);
`endif
        step(0, 0, 0, 4'h5, 0, 0, 1);
        step(0, 0, 0, 4'h5, 0, 0, 1);

        // Randomized traffic with occasional reprogramming
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom & $urandom),
                 4'($urandom), 1'($urandom), $urandom, 1'($urandom));
            if (i == 200) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
